rle_bitstream_writer: RTL and testbench
=======================================

// Module: rle_bitstream_writer
// PURPOSE
//  Parametrised run-length bitstream decompressor with a built-in memory writer.
//  Consumes RLE tokens {value, run} over a valid/ready stream and expands them into
//  a packed bitstream. The stream starts at an arbitrary word address and bit position.
//  Writes go through a DATA_W-wide single-port memory. Partial words use read-modify-write,
//  so neighbouring bits are preserved.
//  Sits between the compressed-input fetch logic and the DMA/RAM port of the IO module.
// PARAMETERS
//  DATA_W  8   memory word width in bits (power of 2, >=8)
//  ADDR_W  16  memory address width
//  RUN_W   7   run-length field width; token is RUN_W+1 bits
//  BIT_W   $clog2(DATA_W)  width of the bit-position fields (derived)
// PORTS
//  clk           in   1        clock, all logic on rising edge
//  RST           in   1        synchronous active-high reset
//  start         in   1        1-cycle pulse: begin a new stream (accepted only when busy=0)
//  base_addr     in   ADDR_W   first word address
//  base_bit      in   BIT_W    first bit position; DATA_W-1 = MSB = empty word
//  tok_valid     in   1        token valid
//  tok_ready     out  1        token accepted when tok_valid & tok_ready
//  tok_data      in   RUN_W+1  [RUN_W] = bit value, [RUN_W-1:0] = run length r (0 legal)
//  tok_last      in   1        qualifies final token of stream
//  mem_addr      out  ADDR_W   memory address
//  mem_wdata     out  DATA_W   write data
//  mem_we        out  1        write strobe, 1 cycle per word
//  mem_re        out  1        read strobe; mem_rdata valid exactly 1 cycle later
//  mem_rdata     in   DATA_W   read data
//  busy          out  1        stream in progress
//  done          out  1        1-cycle pulse when the final word is written
//  end_addr      out  ADDR_W   next free word address (valid from done until next start)
//  end_bit       out  BIT_W    next free bit position
//  bits_written  out  32       total bits expanded for the current stream
// BEHAVIOUR
//  Reset: tok_ready, mem_we, mem_re, busy, done = 0; mem_addr, mem_wdata, end_addr, bits_written = 0.
//   end_bit resets to DATA_W-1. FSM goes to IDLE. RST mid-stream abandons the stream;
//   no write is issued in or after the reset cycle.
//  Bit order: fill from cursor downward (MSB first). When the cursor passes 0, the word
//   is complete; address increments (wraps mod 2^ADDR_W) and cursor returns to DATA_W-1.
//  Word assembly: acc/mask registers. Each FILL cycle places k = min(rem, cursor+1) bits
//   of the value into acc, sets the matching mask bits, and does rem -= k and bits_written += k.
//  States:
//   IDLE:  on start, latch base_addr/base_bit, clear acc/mask/bits_written, busy=1 -> FETCH.
//          start while busy=1 is ignored.
//   FETCH: tok_ready=1. On handshake: rem = r, last_f = tok_last -> FILL.
//          When r=0: no bits placed; go to FLUSH if last_f, else stay in FETCH.
//   FILL:  place bits. When the word completes -> WRITE.
//          Otherwise, when rem hits 0 -> FETCH (or FLUSH if last_f).
//   WRITE: if mask all ones, mem_we=1 with wdata=acc -> continue; else mem_re=1 -> MERGE.
//   MERGE: wait 1 cycle; then mem_we=1, wdata=(mem_rdata & ~mask) | (acc & mask) -> continue.
//   continue: clear acc/mask. Next state: FILL if rem>0; FETCH if rem=0 and !last_f;
//          DONE if last_f and rem=0.
//   FLUSH: if mask==0 -> DONE; else behave as WRITE/MERGE on the partial word -> DONE.
//   DONE:  done=1 for 1 cycle, busy=0, end_addr/end_bit = cursor position -> IDLE.
//  tok_ready is high only in FETCH and is a registered output.
//  A full final word leaves end_bit=DATA_W-1, end_addr=last+1.
//  Each memory word is written at most once per stream; no read is issued for full words.
// TESTING
//  1 base 0x0010 bit7, tok {1,8} last -> one write 0x0010=0xFF, no mem_re,
//    end 0x0011/bit7, bits_written=8.
//  2 mem[0x20]=0xA5, base 0x0020 bit4, tok {0,3} last -> read then write 0x20=0xA1,
//    end 0x0020/bit1.
//  3 mem[0x30]=0x00, mem[0x32]=0xFF, base 0x30 bit2, toks {1,5},{0,13}last ->
//    0x30=0x07 (RMW), 0x31=0xC0 (no read), 0x32=0x01 (RMW);
//    end 0x32/bit0, bits_written=18.
//  4 tok_valid toggled every other cycle; toks {1,0},{1,4}last at bit7, mem[0x40]=0x0F ->
//    0x40=0xFF, exactly one done pulse.
//  5 RST asserted mid-FILL -> next cycle busy=0, mem_we=0, tok_ready=0;
//    a fresh start then runs case 1 correctly.
//  6 start pulsed while busy -> ignored; base_addr unchanged; stream completes as before.

Source files
------------

// File: rtl/rle_bitstream_writer.sv
// Run-length token expander: turns {value, run} tokens into an MSB-first packed
// bitstream in a single-port memory, read-modify-writing partially covered words.
module rle_bitstream_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int RUN_W  = 7,
    parameter int BIT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [BIT_W-1:0]  base_bit,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic [RUN_W:0]    tok_data,
    input  logic              tok_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] end_addr,
    output logic [BIT_W-1:0]  end_bit,
    output logic [31:0]       bits_written
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | tok_ready high, waiting for a token
    // FILL  | placing bits of the current run into acc/mask
    // WRITE | full word: write acc; partial word: issue read
    // MERGE | read data valid: write merged word
    // FLUSH | end of stream: write any partial word left in acc
    // DONE  | one-cycle done pulse, end position published

    localparam int CNT_W = (RUN_W > BIT_W + 1) ? RUN_W : BIT_W + 1;
    localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(DATA_W - 1);
    localparam logic [DATA_W:0]  ONE_W   = {{DATA_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, FETCH, FILL, WRITE, MERGE, FLUSH, DONE} stateT;

    stateT             state, stateN;
    logic [ADDR_W-1:0] addr, addrN;
    logic [BIT_W-1:0]  cursor, cursorN;
    logic [DATA_W-1:0] acc, accN;
    logic [DATA_W-1:0] mask, maskN;
    logic [RUN_W-1:0]  rem, remN;
    logic              valueF, valueN;
    logic              lastF, lastN;
    logic              flushF, flushN;
    logic [31:0]       bitsCnt, bitsN;
    logic              tokReady;
    logic [ADDR_W-1:0] endAddrQ, endAddrN;
    logic [BIT_W-1:0]  endBitQ, endBitN;

    logic              memWe, memRe, doneP, wordDone;
    logic [DATA_W-1:0] memWdata;

    logic [CNT_W-1:0]  cursorP1, remExt, k, shamt;
    logic [DATA_W:0]   oneK;
    logic [DATA_W-1:0] fillMask;
    logic [RUN_W-1:0]  tokRun;

    assign tokRun   = tok_data[RUN_W-1:0];
    assign cursorP1 = CNT_W'(cursor) + CNT_W'(1);
    assign remExt   = CNT_W'(rem);
    assign k        = (remExt < cursorP1) ? remExt : cursorP1;
    assign shamt    = cursorP1 - k;
    assign oneK     = (ONE_W << k) - ONE_W;
    // k bits ending at the cursor, counting downward
    assign fillMask = DATA_W'(oneK << shamt);

    always_comb begin
        stateN   = state;
        addrN    = addr;
        cursorN  = cursor;
        accN     = acc;
        maskN    = mask;
        remN     = rem;
        valueN   = valueF;
        lastN    = lastF;
        flushN   = flushF;
        bitsN    = bitsCnt;
        endAddrN = endAddrQ;
        endBitN  = endBitQ;
        memWe    = 1'b0;
        memRe    = 1'b0;
        memWdata = '0;
        doneP    = 1'b0;
        wordDone = 1'b0;

        case (state)
            IDLE, DONE: begin
                doneP  = (state == DONE);
                stateN = IDLE;
                if (start) begin
                    addrN   = base_addr;
                    cursorN = base_bit;
                    accN    = '0;
                    maskN   = '0;
                    remN    = '0;
                    lastN   = 1'b0;
                    flushN  = 1'b0;
                    bitsN   = '0;
                    stateN  = FETCH;
                end
            end
            FETCH: begin
                if (tok_valid && tokReady) begin
                    valueN = tok_data[RUN_W];
                    lastN  = tok_last;
                    remN   = tokRun;
                    if (tokRun != '0)
                        stateN = FILL;
                    else
                        stateN = tok_last ? FLUSH : FETCH;
                end
            end
            FILL: begin
                accN  = valueF ? (acc | fillMask) : (acc & ~fillMask);
                maskN = mask | fillMask;
                remN  = rem - RUN_W'(k);
                bitsN = bitsCnt + 32'(k);
                if (k == cursorP1) begin
                    // address advances only after the word has been written
                    cursorN = TOP_BIT;
                    stateN  = WRITE;
                end else begin
                    cursorN = cursor - BIT_W'(k);
                    if (remN == '0)
                        stateN = lastF ? FLUSH : FETCH;
                end
            end
            WRITE: begin
                if (&mask) begin
                    memWe    = 1'b1;
                    memWdata = acc;
                    wordDone = 1'b1;
                end else begin
                    memRe  = 1'b1;
                    stateN = MERGE;
                end
            end
            MERGE: begin
                memWe    = 1'b1;
                memWdata = (mem_rdata & ~mask) | (acc & mask);
                wordDone = 1'b1;
            end
            FLUSH: begin
                if (mask == '0) begin
                    stateN = DONE;
                end else begin
                    flushN = 1'b1;
                    stateN = WRITE;
                end
            end
            default: stateN = IDLE;
        endcase

        if (wordDone) begin
            accN  = '0;
            maskN = '0;
            if (flushF) begin
                stateN = DONE;
            end else begin
                addrN = addr + 1'b1;
                if (rem != '0)
                    stateN = FILL;
                else
                    stateN = lastF ? DONE : FETCH;
            end
        end

        if (stateN == DONE && state != DONE) begin
            endAddrN = addrN;
            endBitN  = cursorN;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            addr     <= '0;
            cursor   <= TOP_BIT;
            acc      <= '0;
            mask     <= '0;
            rem      <= '0;
            valueF   <= 1'b0;
            lastF    <= 1'b0;
            flushF   <= 1'b0;
            bitsCnt  <= '0;
            tokReady <= 1'b0;
            endAddrQ <= '0;
            endBitQ  <= TOP_BIT;
        end else begin
            state    <= stateN;
            addr     <= addrN;
            cursor   <= cursorN;
            acc      <= accN;
            mask     <= maskN;
            rem      <= remN;
            valueF   <= valueN;
            lastF    <= lastN;
            flushF   <= flushN;
            bitsCnt  <= bitsN;
            tokReady <= (stateN == FETCH);
            endAddrQ <= endAddrN;
            endBitQ  <= endBitN;
        end
    end

    // strobes are masked by RST so an abandoned stream cannot land a write
    assign mem_we       = memWe & ~RST;
    assign mem_re       = memRe & ~RST;
    assign mem_addr     = addr;
    assign mem_wdata    = memWdata;
    assign tok_ready    = tokReady;
    assign busy         = (state != IDLE) && (state != DONE);
    assign done         = doneP;
    assign end_addr     = endAddrQ;
    assign end_bit      = endBitQ;
    assign bits_written = bitsCnt;

endmodule

// File: tb/tb_rle_bitstream_writer.sv
// Bench for rle_bitstream_writer: directed vector table, reset/start corner
// sequences, and random streams checked against a bit-position memory model.
module tb_rle_bitstream_writer;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] base_addr;
    logic [2:0]  base_bit;
    logic        tok_valid;
    logic        tok_ready;
    logic [7:0]  tok_data;
    logic        tok_last;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [15:0] end_addr;
    logic [2:0]  end_bit;
    logic [31:0] bits_written;

    always #5 clk = ~clk;

    rle_bitstream_writer #(.DATA_W(8), .ADDR_W(16), .RUN_W(7)) dut (
        .clk(clk), .RST(RST), .start(start), .base_addr(base_addr), .base_bit(base_bit),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data), .tok_last(tok_last),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .end_addr(end_addr),
        .end_bit(end_bit), .bits_written(bits_written)
    );

    logic [7:0]  mem [0:65535];
    logic        preWe = 1'b0;
    logic [15:0] preAddr = '0;
    logic [7:0]  preData = '0;
    int          wrCount = 0, rdCount = 0, doneCount = 0, rstWrites = 0;
    logic [15:0] wrLog [$];

    always @(posedge clk) begin
        if (preWe) mem[preAddr] <= preData;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_we) begin
            wrCount++;
            wrLog.push_back(mem_addr);
            if (RST) rstWrites++;
        end
        if (mem_re) rdCount++;
        if (done) doneCount++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        preWe = 1'b1; preAddr = a; preData = d;
        @(negedge clk);
        preWe = 1'b0;
    endtask

    logic [7:0] tokQ [$];

    task automatic runStream(input logic [15:0] a, input logic [2:0] b, input bit gap,
                             input bit glitch, output int nWr, output int nRd,
                             output int nDone, output bit dup);
        int wr0, rd0, dn0, lg0, guard;
        @(negedge clk);
        wr0 = wrCount; rd0 = rdCount; dn0 = doneCount; lg0 = wrLog.size();
        start = 1'b1; base_addr = a; base_bit = b;
        @(negedge clk);
        start = 1'b0; base_addr = 16'($urandom); base_bit = 3'($urandom);
        for (int i = 0; i < tokQ.size(); i++) begin
            if (gap) begin
                tok_valid = 1'b0;
                @(negedge clk);
            end
            tok_valid = 1'b1; tok_data = tokQ[i]; tok_last = (i == tokQ.size() - 1);
            guard = 0;
            while (!tok_ready && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 400) timeoutFail("tok_accept");
            @(negedge clk);
            tok_valid = 1'b0; tok_last = 1'b0;
            if (glitch && i == 0) begin
                start = 1'b1; base_addr = 16'h9999; base_bit = 3'd0;
                @(negedge clk);
                start = 1'b0;
            end
        end
        guard = 0;
        while (doneCount == dn0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) timeoutFail("done_wait");
        repeat (3) @(negedge clk);
        nWr = wrCount - wr0; nRd = rdCount - rd0; nDone = doneCount - dn0;
        dup = 1'b0;
        for (int i = lg0; i < wrLog.size(); i++)
            for (int j = i + 1; j < wrLog.size(); j++)
                if (wrLog[i] == wrLog[j]) dup = 1'b1;
    endtask

    typedef struct packed {
        logic [15:0]     addr;
        logic [2:0]      bitPos;
        logic [1:0]      nTok;
        logic [1:0][7:0] toks;
        logic            gap;
        logic            glitch;
        logic [2:0][7:0] pre;
        logic [2:0][7:0] exp;
        logic [15:0]     endAddr;
        logic [2:0]      endBit;
        logic [31:0]     bits;
        logic [7:0]      nWr;
        logic [7:0]      nRd;
    } vec_t;

    function automatic vec_t mkVec(input logic [15:0] a, input logic [2:0] b, input int nTok,
                                   input logic [7:0] t0, input logic [7:0] t1,
                                   input bit gap, input bit glitch,
                                   input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                                   input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                   input logic [15:0] ea, input logic [2:0] eb,
                                   input int bits, input int nWr, input int nRd);
        vec_t v;
        v.addr = a; v.bitPos = b; v.nTok = 2'(nTok); v.toks = {t1, t0};
        v.gap = gap; v.glitch = glitch;
        v.pre = {p2, p1, p0}; v.exp = {e2, e1, e0};
        v.endAddr = ea; v.endBit = eb; v.bits = 32'(bits); v.nWr = 8'(nWr); v.nRd = 8'(nRd);
        return v;
    endfunction

    task automatic applyVec(input vec_t v, input string tag);
        int nWr, nRd, nDone;
        bit dup;
        for (int j = 0; j < 3; j++) preload(v.addr + 16'(j), v.pre[j]);
        if (v.glitch) preload(16'h9999, 8'h3C);
        tokQ.delete();
        for (int i = 0; i < int'(v.nTok); i++) tokQ.push_back(v.toks[i]);
        runStream(v.addr, v.bitPos, v.gap, v.glitch, nWr, nRd, nDone, dup);
        for (int j = 0; j < 3; j++)
            check($sformatf("%s_word%0d", tag, j), 32'(mem[v.addr + 16'(j)]), 32'(v.exp[j]));
        check({tag, "_end_addr"}, 32'(end_addr), 32'(v.endAddr));
        check({tag, "_end_bit"}, 32'(end_bit), 32'(v.endBit));
        check({tag, "_bits"}, bits_written, v.bits);
        check({tag, "_writes"}, 32'(nWr), 32'(v.nWr));
        check({tag, "_reads"}, 32'(nRd), 32'(v.nRd));
        check({tag, "_done_pulses"}, 32'(nDone), 32'd1);
        check({tag, "_dup_write"}, 32'(dup), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (v.glitch) check({tag, "_stray_word"}, 32'(mem[16'h9999]), 32'h3C);
    endtask

    vec_t vecs [0:6];

    initial begin
        int guard, wr0, rw0;

        RST = 1'b1; start = 1'b0; base_addr = '0; base_bit = '0;
        tok_valid = 1'b0; tok_data = '0; tok_last = 1'b0;

        vecs[0] = mkVec(16'h0010, 3'd7, 1, 8'h88, 8'h00, 0, 0, 8'h33, 8'h44, 8'h55,
                        8'hFF, 8'h44, 8'h55, 16'h0011, 3'd7, 8, 1, 0);
        vecs[1] = mkVec(16'h0020, 3'd4, 1, 8'h03, 8'h00, 0, 0, 8'hA5, 8'h11, 8'h22,
                        8'hA1, 8'h11, 8'h22, 16'h0020, 3'd1, 3, 1, 1);
        vecs[2] = mkVec(16'h0030, 3'd2, 2, 8'h85, 8'h0D, 0, 0, 8'h00, 8'h5A, 8'hFF,
                        8'h07, 8'hC0, 8'h01, 16'h0032, 3'd0, 18, 3, 2);
        vecs[3] = mkVec(16'h0040, 3'd7, 2, 8'h80, 8'h84, 1, 0, 8'h0F, 8'h66, 8'h77,
                        8'hFF, 8'h66, 8'h77, 16'h0040, 3'd3, 4, 1, 1);
        vecs[4] = mkVec(16'h0060, 3'd2, 2, 8'h85, 8'h0D, 0, 1, 8'h00, 8'h5A, 8'hFF,
                        8'h07, 8'hC0, 8'h01, 16'h0062, 3'd0, 18, 3, 2);
        vecs[5] = mkVec(16'h0070, 3'd5, 1, 8'h80, 8'h00, 0, 0, 8'h5A, 8'h6B, 8'h7C,
                        8'h5A, 8'h6B, 8'h7C, 16'h0070, 3'd5, 0, 0, 0);
        vecs[6] = mkVec(16'hFFFF, 3'd3, 1, 8'h8C, 8'h00, 0, 0, 8'hA0, 8'h12, 8'h34,
                        8'hAF, 8'hFF, 8'h34, 16'h0001, 3'd7, 12, 2, 1);

        repeat (3) @(negedge clk);
        check("rst_tok_ready", 32'(tok_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_re", 32'(mem_re), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_end_addr", 32'(end_addr), 0);
        check("rst_end_bit", 32'(end_bit), 7);
        check("rst_bits", bits_written, 0);
        RST = 1'b0;

        for (int i = 0; i < 7; i++) applyVec(vecs[i], $sformatf("vec%0d", i));

        // reset in the middle of a long run, landing on a full-word write cycle
        for (int j = 0; j < 3; j++) preload(16'h0050 + 16'(j), 8'h00);
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0050; base_bit = 3'd7;
        @(negedge clk);
        start = 1'b0; tok_valid = 1'b1; tok_data = 8'hE4; tok_last = 1'b1;
        guard = 0;
        while (!tok_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) timeoutFail("rst_tok_accept");
        @(negedge clk);
        tok_valid = 1'b0; tok_last = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 1);
        rw0 = rstWrites;
        RST = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_mem_we", 32'(mem_we), 0);
        check("midrst_tok_ready", 32'(tok_ready), 0);
        check("midrst_write_in_rst", 32'(rstWrites - rw0), 0);
        RST = 1'b0;
        wr0 = wrCount;
        repeat (20) @(negedge clk);
        check("midrst_no_more_writes", 32'(wrCount - wr0), 0);
        applyVec(vecs[0], "after_rst");

        for (int n = 0; n < 25; n++) begin
            logic [15:0] a;
            logic [2:0]  b;
            logic [15:0] ea;
            logic [2:0]  eb;
            logic [7:0]  mdl [0:79];
            int          cov [0:79];
            int          nt, r, total, l0, pos, nw, expRd, nWr, nRd, nDone;
            bit          val, gap, dup;

            a = 16'($urandom);
            if (n % 5 == 0) a = 16'hFFF8 + 16'($urandom_range(0, 7));
            b = 3'($urandom);
            gap = 1'($urandom);
            nt = $urandom_range(1, 4);
            tokQ.delete();
            total = 0;
            for (int i = 0; i < nt; i++) begin
                r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
                val = 1'($urandom);
                tokQ.push_back({val, 7'(r)});
                total += r;
            end

            // bit positions counted from the MSB of word a; mdl[k] is word a-1+k
            l0 = 7 - int'(b);
            nw = (total == 0) ? 0 : ((l0 + total - 1) >> 3) + 1;
            for (int k = 0; k < nw + 2; k++) begin
                mdl[k] = 8'($urandom);
                cov[k] = 0;
                preload(a - 16'd1 + 16'(k), mdl[k]);
            end
            pos = l0;
            for (int i = 0; i < nt; i++) begin
                for (int s = 0; s < int'(tokQ[i][6:0]); s++) begin
                    mdl[(pos >> 3) + 1][7 - (pos & 7)] = tokQ[i][7];
                    cov[(pos >> 3) + 1]++;
                    pos++;
                end
            end
            expRd = 0;
            for (int k = 1; k <= nw; k++) if (cov[k] < 8) expRd++;
            ea = a + 16'(pos >> 3);
            eb = 3'(7 - (pos & 7));

            runStream(a, b, gap, 1'b0, nWr, nRd, nDone, dup);
            for (int k = 0; k < nw + 2; k++)
                check($sformatf("rand%0d_word%0d", n, k), 32'(mem[a - 16'd1 + 16'(k)]), 32'(mdl[k]));
            check($sformatf("rand%0d_end_addr", n), 32'(end_addr), 32'(ea));
            check($sformatf("rand%0d_end_bit", n), 32'(end_bit), 32'(eb));
            check($sformatf("rand%0d_bits", n), bits_written, 32'(total));
            check($sformatf("rand%0d_writes", n), 32'(nWr), 32'(nw));
            check($sformatf("rand%0d_reads", n), 32'(nRd), 32'(expRd));
            check($sformatf("rand%0d_done_pulses", n), 32'(nDone), 32'd1);
            check($sformatf("rand%0d_dup_write", n), 32'(dup), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
